// File: rtl/usb_line_state_detector.sv
`default_nettype none
// ============================================================================
// Module  : usb_line_state_detector
// Brief   : USB RX line-state monitor: D+/D- sync, SE0/J/K/SE1 decode, EOP,
//           bus-reset, bad-EOP, SE1 and idle detection. Optional macro
//           USB_LINE_GLITCH_FILTER_EN adds a 2-clock stability filter.
// Rev     : 1.0  initial release
// ============================================================================
module usb_line_state_detector #(
    parameter int SYNC_STAGES  = 2,
    parameter int EOP_MIN_CLKS = 48,
    parameter int RESET_CLKS   = 120,
    parameter int IDLE_CLKS    = 224,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       low_speed,
    input  logic       d_plus,
    input  logic       d_minus,
    output logic [1:0] line_state,
    output logic       rx_eop,
    output logic       eop_err,
    output logic       se1_err,
    output logic       bus_reset,
    output logic       idle
);

    localparam logic [1:0]       c_ls_se0     = 2'b00;
    localparam logic [1:0]       c_ls_j       = 2'b01;
    localparam logic [1:0]       c_ls_k       = 2'b10;
    localparam logic [1:0]       c_ls_se1     = 2'b11;
    localparam logic [CNT_W-1:0] c_eop_last   = CNT_W'(EOP_MIN_CLKS - 1);
    localparam logic [CNT_W-1:0] c_reset_last = CNT_W'(RESET_CLKS - 1);
    localparam logic [CNT_W-1:0] c_idle_last  = CNT_W'(IDLE_CLKS - 1);
    localparam logic [CNT_W-1:0] c_run_max    = '1;

    typedef enum logic [1:0] {
        ST_IDLE_WAIT = 2'd0,
        ST_ACTIVE    = 2'd1,
        ST_SE0_RUN   = 2'd2,
        ST_BUS_RESET = 2'd3
    } state_t;

    logic [SYNC_STAGES-1:0] r_dp_sync;
    logic [SYNC_STAGES-1:0] r_dm_sync;
    logic [1:0]             w_pair;
    logic [1:0]             w_dec_pair;
    logic [1:0]             w_ls;
    logic [1:0]             r_line_state;
    logic [CNT_W-1:0]       r_run;
    state_t                 r_state;
    logic                   r_prior_active;
    logic                   r_eop_ok;
    logic                   r_rx_eop;
    logic                   r_eop_err;
    logic                   r_se1_err;
    logic                   r_bus_reset;
    logic                   r_idle;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dp_sync <= '0;
            r_dm_sync <= '0;
        end else begin
            r_dp_sync <= {r_dp_sync[SYNC_STAGES-2:0], d_plus};
            r_dm_sync <= {r_dm_sync[SYNC_STAGES-2:0], d_minus};
        end
    end

    assign w_pair = {r_dp_sync[SYNC_STAGES-1], r_dm_sync[SYNC_STAGES-1]};

`ifdef USB_LINE_GLITCH_FILTER_EN
    logic [1:0] r_filt_prev;
    logic [1:0] r_filt_out;

    // A new pair is only passed on once it has been seen on two consecutive clocks.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_filt_prev <= 2'b00;
            r_filt_out  <= 2'b00;
        end else begin
            r_filt_prev <= w_pair;
            if (w_pair == r_filt_prev) begin
                r_filt_out <= w_pair;
            end
        end
    end

    assign w_dec_pair = r_filt_out;
`else
    assign w_dec_pair = w_pair;
`endif

    always_comb begin
        w_ls = c_ls_se0;
        case (w_dec_pair)
            2'b00:   w_ls = c_ls_se0;
            2'b11:   w_ls = c_ls_se1;
            2'b10:   w_ls = low_speed ? c_ls_k : c_ls_j;
            default: w_ls = low_speed ? c_ls_j : c_ls_k;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_line_state   <= c_ls_se0;
            r_run          <= '0;
            r_state        <= ST_IDLE_WAIT;
            r_prior_active <= 1'b0;
            r_eop_ok       <= 1'b0;
            r_rx_eop       <= 1'b0;
            r_eop_err      <= 1'b0;
            r_se1_err      <= 1'b0;
            r_bus_reset    <= 1'b0;
            r_idle         <= 1'b0;
        end else begin
            r_line_state <= w_ls;
            if (w_ls != r_line_state) begin
                r_run <= '0;
            end else if (r_run != c_run_max) begin
                r_run <= r_run + 1'b1;
            end

            r_idle    <= (r_line_state == c_ls_j) && (r_run >= c_idle_last);
            // The counter is zero only on the first clock of a new line state.
            r_se1_err <= (r_line_state == c_ls_se1) && (r_run == '0);
            r_rx_eop  <= 1'b0;
            r_eop_err <= 1'b0;

            case (r_state)
                ST_IDLE_WAIT, ST_ACTIVE: begin
                    if (r_line_state == c_ls_se0) begin
                        r_state        <= ST_SE0_RUN;
                        r_prior_active <= (r_state == ST_ACTIVE);
                        r_eop_ok       <= (r_run >= c_eop_last);
                    end else if (r_line_state == c_ls_k) begin
                        r_state <= ST_ACTIVE;
                    end
                end
                ST_SE0_RUN: begin
                    if (r_line_state == c_ls_se0) begin
                        // r_eop_ok tracks the SE0 length seen up to the last SE0 clock.
                        r_eop_ok <= (r_run >= c_eop_last);
                        if (r_run >= c_reset_last) begin
                            r_state     <= ST_BUS_RESET;
                            r_bus_reset <= 1'b1;
                        end
                    end else if (r_eop_ok) begin
                        if (r_line_state == c_ls_j) begin
                            r_rx_eop <= 1'b1;
                            r_state  <= ST_IDLE_WAIT;
                        end else begin
                            r_eop_err <= 1'b1;
                            r_state   <= ST_ACTIVE;
                        end
                    end else begin
                        r_state <= r_prior_active ? ST_ACTIVE : ST_IDLE_WAIT;
                    end
                end
                default: begin
                    if (r_line_state != c_ls_se0) begin
                        r_bus_reset <= 1'b0;
                        r_state     <= ST_IDLE_WAIT;
                    end
                end
            endcase
        end
    end

    assign line_state = r_line_state;
    assign rx_eop     = r_rx_eop;
    assign eop_err    = r_eop_err;
    assign se1_err    = r_se1_err;
    assign bus_reset  = r_bus_reset;
    assign idle       = r_idle;

endmodule
`default_nettype wire
